// File: rtl/axi_burst_ram.sv
// axi_burst_ram: word-addressed AXI4 slave memory with independent read and
// write burst engines (FIXED / INCR / WRAP, up to 256 beats).
// Memory contents are never touched by reset; only the channel FSMs are.
// Optional feature macro: AXI_RAM_BOUNDS_CHECK_EN. When defined, beats beyond
// DEPTH_WORDS*BPB bytes answer SLVERR; when undefined, addresses alias.
`timescale 1ns/1ps
module axi_burst_ram #(
    parameter int DATA_W      = 64,
    parameter int DEPTH_WORDS = 4096,
    parameter int ADDR_W      = 32,
    parameter int ID_W        = 4
) (
    input  logic                clk,
    input  logic                rst,
    // read slave: AR channel
    input  logic [ID_W-1:0]     arid_i,
    input  logic [ADDR_W-1:0]   araddr_i,
    input  logic [7:0]          arlen_i,
    input  logic [1:0]          arburst_i,
    input  logic                arvalid_i,
    output logic                arready_o,
    // read slave: R channel
    output logic [ID_W-1:0]     rid_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic [1:0]          rresp_o,
    output logic                rlast_o,
    output logic                rvalid_o,
    input  logic                rready_i,
    // write slave: AW channel
    input  logic [ID_W-1:0]     awid_i,
    input  logic [ADDR_W-1:0]   awaddr_i,
    input  logic [7:0]          awlen_i,
    input  logic [1:0]          awburst_i,
    input  logic                awvalid_i,
    output logic                awready_o,
    // write slave: W channel
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    input  logic                wlast_i,
    input  logic                wvalid_i,
    output logic                wready_o,
    // write slave: B channel
    output logic [ID_W-1:0]     bid_o,
    output logic [1:0]          bresp_o,
    output logic                bvalid_o,
    input  logic                bready_i
);

    localparam int BPB   = DATA_W / 8;
    localparam int OFS   = $clog2(BPB);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic {
        RD_IDLE,
        RD_DATA
    } rd_state_e;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_DATA,
        WR_RESP
    } wr_state_e;

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

    // Word index: byte-lane bits and everything above the memory depth are dropped.
    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
        return addr[OFS +: IDX_W];
    endfunction

`ifdef AXI_RAM_BOUNDS_CHECK_EN
    // Any address bit above the implemented range marks the beat as out of range.
    function automatic logic out_of_range(input logic [ADDR_W-1:0] addr);
        return |addr[ADDR_W-1:OFS+IDX_W];
    endfunction
`else
    // Without bounds checking the upper bits simply alias.
    function automatic logic out_of_range(input logic [ADDR_W-1:0] addr);
        return 1'b0;
    endfunction
`endif

    // Address of the following beat. WRAP keeps the bits above the
    // (len+1)*BPB container and lets only the bits inside it roll over.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                    input logic [7:0]        len,
                                                    input logic [1:0]        burst);
        logic [ADDR_W-1:0] inc;
        logic [ADDR_W-1:0] mask;
        inc  = addr + ADDR_W'(BPB);
        mask = ((ADDR_W'(len) + ADDR_W'(1)) << OFS) - ADDR_W'(1);
        case (burst)
            2'b00:   return addr;
            2'b10:   return (addr & ~mask) | (inc & mask);
            default: return inc;
        endcase
    endfunction

    // ---------------- read channel state ----------------
    rd_state_e         rd_state_q;
    logic [ID_W-1:0]   rid_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] rd_addr_d;
    logic [7:0]        rd_len_q;
    logic [1:0]        rd_burst_q;
    logic [7:0]        rd_beat_q;
    logic              rlast_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rresp_q;

    // ---------------- write channel state ----------------
    wr_state_e         wr_state_q;
    logic [ID_W-1:0]   bid_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [7:0]        wr_len_q;
    logic [1:0]        wr_burst_q;
    logic [7:0]        wr_beat_q;
    logic              wr_err_q;
    logic [ADDR_W-1:0] wr_tgt;
    logic              wr_fire;
    logic              wr_en;

    // The burst length comes from awlen alone, so wlast carries no information.
    logic unused_sigs;
    assign unused_sigs = wlast_i;

    assign rd_addr_d = next_addr(rd_addr_q, rd_len_q, rd_burst_q);
    assign wr_addr_d = next_addr(wr_addr_q, wr_len_q, wr_burst_q);

    // Handshake outputs are forced low while reset is held.
    assign arready_o = !rst && (rd_state_q == RD_IDLE);
    assign rvalid_o  = !rst && (rd_state_q == RD_DATA);
    assign awready_o = !rst && (wr_state_q == WR_IDLE);
    assign wready_o  = !rst && (((wr_state_q == WR_IDLE) && awvalid_i) ||
                                (wr_state_q == WR_DATA));
    assign bvalid_o  = !rst && (wr_state_q == WR_RESP);

    assign rid_o   = rid_q;
    assign rdata_o = rdata_q;
    assign rresp_o = rresp_q;
    assign rlast_o = rlast_q;
    assign bid_o   = bid_q;
    assign bresp_o = wr_err_q ? 2'b10 : 2'b00;

    // Beat 0 rides with AW in idle and uses awaddr; later beats use the burst address.
    assign wr_tgt  = (wr_state_q == WR_IDLE) ? awaddr_i : wr_addr_q;
    assign wr_fire = wvalid_i && wready_o;
    assign wr_en   = wr_fire && !out_of_range(wr_tgt);

    // Byte-strobed memory write; the read engine samples the pre-write value on the same edge.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BPB; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[word_idx(wr_tgt)][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // Read FSM: registers the beat data so R payload holds steady under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= RD_IDLE;
        end else begin
            case (rd_state_q)
                RD_IDLE: begin
                    if (arvalid_i) begin
                        rd_state_q <= RD_DATA;
                        rid_q      <= arid_i;
                        rd_addr_q  <= araddr_i;
                        rd_len_q   <= arlen_i;
                        rd_burst_q <= arburst_i;
                        rd_beat_q  <= 8'd0;
                        rlast_q    <= (arlen_i == 8'd0);
                        rdata_q    <= out_of_range(araddr_i) ? '0 : mem_q[word_idx(araddr_i)];
                        rresp_q    <= out_of_range(araddr_i) ? 2'b10 : 2'b00;
                    end
                end
                RD_DATA: begin
                    if (rready_i) begin
                        if (rlast_q) begin
                            rd_state_q <= RD_IDLE;
                        end else begin
                            rd_beat_q <= rd_beat_q + 8'd1;
                            rd_addr_q <= rd_addr_d;
                            rlast_q   <= ((rd_beat_q + 8'd1) == rd_len_q);
                            rdata_q   <= out_of_range(rd_addr_d) ? '0 : mem_q[word_idx(rd_addr_d)];
                            rresp_q   <= out_of_range(rd_addr_d) ? 2'b10 : 2'b00;
                        end
                    end
                end
                default: rd_state_q <= RD_IDLE;
            endcase
        end
    end

    // Write FSM: accepts AW (optionally with beat 0), counts W beats, then issues B.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q <= WR_IDLE;
        end else begin
            case (wr_state_q)
                WR_IDLE: begin
                    if (awvalid_i) begin
                        bid_q      <= awid_i;
                        wr_len_q   <= awlen_i;
                        wr_burst_q <= awburst_i;
                        if (wvalid_i) begin
                            wr_err_q   <= out_of_range(awaddr_i);
                            wr_addr_q  <= next_addr(awaddr_i, awlen_i, awburst_i);
                            wr_beat_q  <= 8'd1;
                            wr_state_q <= (awlen_i == 8'd0) ? WR_RESP : WR_DATA;
                        end else begin
                            wr_err_q   <= 1'b0;
                            wr_addr_q  <= awaddr_i;
                            wr_beat_q  <= 8'd0;
                            wr_state_q <= WR_DATA;
                        end
                    end
                end
                WR_DATA: begin
                    if (wvalid_i) begin
                        wr_err_q  <= wr_err_q | out_of_range(wr_addr_q);
                        wr_addr_q <= wr_addr_d;
                        wr_beat_q <= wr_beat_q + 8'd1;
                        if (wr_beat_q == wr_len_q) begin
                            wr_state_q <= WR_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    if (bready_i) begin
                        wr_state_q <= WR_IDLE;
                    end
                end
                default: wr_state_q <= WR_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_burst_ram.sv
// Directed bench for axi_burst_ram: write bursts, a table of read bursts with
// hand-computed data, plus hand-driven reset, same-cycle and bounds sequences.
`timescale 1ns/1ps
module tb_axi_burst_ram;

    localparam int DATA_W      = 64;
    localparam int DEPTH_WORDS = 4096;
    localparam int ADDR_W      = 32;
    localparam int ID_W        = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [ID_W-1:0]   arid_i;
    logic [ADDR_W-1:0] araddr_i;
    logic [7:0]        arlen_i;
    logic [1:0]        arburst_i;
    logic              arvalid_i;
    logic              arready_o;
    logic [ID_W-1:0]   rid_o;
    logic [DATA_W-1:0] rdata_o;
    logic [1:0]        rresp_o;
    logic              rlast_o;
    logic              rvalid_o;
    logic              rready_i;
    logic [ID_W-1:0]   awid_i;
    logic [ADDR_W-1:0] awaddr_i;
    logic [7:0]        awlen_i;
    logic [1:0]        awburst_i;
    logic              awvalid_i;
    logic              awready_o;
    logic [DATA_W-1:0] wdata_i;
    logic [7:0]        wstrb_i;
    logic              wlast_i;
    logic              wvalid_i;
    logic              wready_o;
    logic [ID_W-1:0]   bid_o;
    logic [1:0]        bresp_o;
    logic              bvalid_o;
    logic              bready_i;

    always #5 clk = ~clk;

    axi_burst_ram #(
        .DATA_W(DATA_W), .DEPTH_WORDS(DEPTH_WORDS), .ADDR_W(ADDR_W), .ID_W(ID_W)
    ) dut (
        .clk(clk), .rst(rst),
        .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i), .arburst_i(arburst_i),
        .arvalid_i(arvalid_i), .arready_o(arready_o),
        .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
        .rvalid_o(rvalid_o), .rready_i(rready_i),
        .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i), .awburst_i(awburst_i),
        .awvalid_i(awvalid_i), .awready_o(awready_o),
        .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i), .wvalid_i(wvalid_i),
        .wready_o(wready_o),
        .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0]      addr;
        logic [7:0]       len;
        logic [1:0]       burst;
        logic [15:0]      pat;
        logic [7:0][63:0] exp;
    } rd_vec_t;

    function automatic logic [7:0][63:0] ev(input logic [63:0] e0, e1, e2, e3, e4, e5, e6, e7);
        logic [7:0][63:0] r;
        r[0] = e0; r[1] = e1; r[2] = e2; r[3] = e3;
        r[4] = e4; r[5] = e5; r[6] = e6; r[7] = e7;
        return r;
    endfunction

    task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input logic [3:0] id, input logic [63:0] base, input logic [7:0] strb,
                             input bit w0_with_aw, input logic [1:0] exp_resp, input string tag);
        int guard;
        @(negedge clk);
        awaddr_i = addr; awlen_i = len; awburst_i = burst; awid_i = id; awvalid_i = 1'b1;
        wdata_i = base; wstrb_i = strb; wlast_i = (len == 8'd0); wvalid_i = w0_with_aw;
        guard = 0;
        while (!awready_o && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_awready"}, 64'(awready_o), 64'd1);
        @(negedge clk);
        awvalid_i = 1'b0;
        wvalid_i  = 1'b0;
        for (int b = (w0_with_aw ? 1 : 0); b <= int'(len); b++) begin
            wdata_i  = base + 64'(b);
            wlast_i  = (b == int'(len));
            wvalid_i = 1'b1;
            guard = 0;
            while (!wready_o && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            @(negedge clk);
        end
        wvalid_i = 1'b0;
        wlast_i  = 1'b0;
        chk({tag, "_bvalid"}, 64'(bvalid_o), 64'd1);
        chk({tag, "_bresp"}, 64'(bresp_o), 64'(exp_resp));
        chk({tag, "_bid"}, 64'(bid_o), 64'(id));
        bready_i = 1'b1;
        @(negedge clk);
        bready_i = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [3:0] id, input logic [15:0] pat, input logic [7:0][63:0] exp,
                            input logic [1:0] exp_resp, input string tag);
        int guard, cyc, n, lasts;
        bit stalled;
        logic [63:0] held_data;
        logic held_last;
        @(negedge clk);
        araddr_i = addr; arlen_i = len; arburst_i = burst; arid_i = id; arvalid_i = 1'b1;
        guard = 0;
        while (!arready_o && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_arready"}, 64'(arready_o), 64'd1);
        @(negedge clk);
        arvalid_i = 1'b0;
        chk({tag, "_r_latency"}, 64'(rvalid_o), 64'd1);
        cyc = 0; n = 0; lasts = 0; stalled = 1'b0;
        held_data = '0; held_last = 1'b0;
        while (n <= int'(len) && cyc < 200) begin
            rready_i = pat[cyc % 16];
            if (rvalid_o) begin
                if (stalled) begin
                    chk($sformatf("%s_hold_data%0d", tag, n), rdata_o, held_data);
                    chk($sformatf("%s_hold_last%0d", tag, n), 64'(rlast_o), 64'(held_last));
                end
                if (rready_i) begin
                    if (n < 8) chk($sformatf("%s_data%0d", tag, n), rdata_o, exp[n]);
                    chk($sformatf("%s_last%0d", tag, n), 64'(rlast_o), 64'(n == int'(len)));
                    chk($sformatf("%s_resp%0d", tag, n), 64'(rresp_o), 64'(exp_resp));
                    chk($sformatf("%s_rid%0d", tag, n), 64'(rid_o), 64'(id));
                    if (rlast_o) lasts++;
                    n++;
                    stalled = 1'b0;
                end else begin
                    stalled   = 1'b1;
                    held_data = rdata_o;
                    held_last = rlast_o;
                end
            end
            @(negedge clk);
            cyc++;
        end
        rready_i = 1'b0;
        chk({tag, "_beats"}, 64'(n), 64'(int'(len) + 1));
        chk({tag, "_rlast_count"}, 64'(lasts), 64'd1);
        chk({tag, "_idle_after"}, 64'(rvalid_o), 64'd0);
    endtask

    localparam int NV = 9;
    rd_vec_t vecs [NV];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        arid_i = '0; araddr_i = '0; arlen_i = '0; arburst_i = '0; arvalid_i = 1'b0;
        rready_i = 1'b0;
        awid_i = '0; awaddr_i = '0; awlen_i = '0; awburst_i = '0; awvalid_i = 1'b0;
        wdata_i = '0; wstrb_i = '0; wlast_i = 1'b0; wvalid_i = 1'b0;
        bready_i = 1'b0;

        vecs[0] = '{32'h100, 8'd7, 2'b11, 16'hFFFF,
                    ev(64'hA0, 64'hA1, 64'hA2, 64'hA3, 64'hA4, 64'hA5, 64'hA6, 64'hA7)};
        vecs[1] = '{32'h40, 8'd0, 2'b01, 16'hFFFF,
                    ev(64'hFFFF_FFFF_0000_0000, 0, 0, 0, 0, 0, 0, 0)};
        vecs[2] = '{32'h100, 8'd7, 2'b01, 16'h9999,
                    ev(64'hA0, 64'hA1, 64'hA2, 64'hA3, 64'hA4, 64'hA5, 64'hA6, 64'hA7)};
        vecs[3] = '{32'h118, 8'd3, 2'b10, 16'hFFFF,
                    ev(64'hA3, 64'hA0, 64'hA1, 64'hA2, 0, 0, 0, 0)};
        vecs[4] = '{32'h108, 8'd1, 2'b10, 16'hFFFF,
                    ev(64'hA1, 64'hA0, 0, 0, 0, 0, 0, 0)};
        vecs[5] = '{32'h108, 8'd3, 2'b00, 16'hFFFF,
                    ev(64'hA1, 64'hA1, 64'hA1, 64'hA1, 0, 0, 0, 0)};
        vecs[6] = '{32'h200, 8'd0, 2'b01, 16'hFFFF,
                    ev(64'h56, 0, 0, 0, 0, 0, 0, 0)};
        vecs[7] = '{32'h204, 8'd0, 2'b01, 16'hFFFF,
                    ev(64'h56, 0, 0, 0, 0, 0, 0, 0)};
        vecs[8] = '{32'h130, 8'd7, 2'b10, 16'hFFFF,
                    ev(64'hA6, 64'hA7, 64'hA0, 64'hA1, 64'hA2, 64'hA3, 64'hA4, 64'hA5)};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_arready", 64'(arready_o), 64'd0);
        chk("rst_awready", 64'(awready_o), 64'd0);
        chk("rst_wready",  64'(wready_o),  64'd0);
        chk("rst_rvalid",  64'(rvalid_o),  64'd0);
        chk("rst_bvalid",  64'(bvalid_o),  64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_arready", 64'(arready_o), 64'd1);
        chk("post_rst_awready", 64'(awready_o), 64'd1);

        // W without AW is refused in idle
        wvalid_i = 1'b1; wdata_i = 64'hDEAD; wstrb_i = 8'hFF;
        #1;
        chk("w_without_aw", 64'(wready_o), 64'd0);
        @(negedge clk);
        wvalid_i = 1'b0;

        // writes that build the memory image read back below
        axi_write(32'h100, 8'd7, 2'b11, 4'd1, 64'hA0, 8'hFF, 1'b1, 2'b00, "wr_incr");
        axi_write(32'h40, 8'd0, 2'b01, 4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1, 2'b00, "wr_ones");
        axi_write(32'h40, 8'd0, 2'b01, 4'd2, 64'h0, 8'h0F, 1'b1, 2'b00, "wr_strb");
        axi_write(32'h200, 8'd1, 2'b00, 4'd3, 64'h55, 8'hFF, 1'b0, 2'b00, "wr_fixed");

        // table of read bursts
        for (int i = 0; i < NV; i++) begin
            axi_read(vecs[i].addr, vecs[i].len, vecs[i].burst, 4'(i), vecs[i].pat,
                     vecs[i].exp, 2'b00, $sformatf("rd%0d", i));
        end

        // same word read and written in one cycle: read returns the old value
        axi_write(32'h300, 8'd0, 2'b01, 4'd4, 64'h11, 8'hFF, 1'b1, 2'b00, "wr_pre");
        @(negedge clk);
        araddr_i = 32'h300; arlen_i = 8'd0; arburst_i = 2'b01; arid_i = 4'd5; arvalid_i = 1'b1;
        awaddr_i = 32'h300; awlen_i = 8'd0; awburst_i = 2'b01; awid_i = 4'd6; awvalid_i = 1'b1;
        wdata_i = 64'h22; wstrb_i = 8'hFF; wlast_i = 1'b1; wvalid_i = 1'b1;
        #1;
        chk("rbw_arready", 64'(arready_o), 64'd1);
        chk("rbw_wready",  64'(wready_o),  64'd1);
        @(negedge clk);
        arvalid_i = 1'b0; awvalid_i = 1'b0; wvalid_i = 1'b0; wlast_i = 1'b0;
        chk("rbw_rvalid", 64'(rvalid_o), 64'd1);
        chk("rbw_old_data", rdata_o, 64'h11);
        chk("rbw_bvalid", 64'(bvalid_o), 64'd1);
        rready_i = 1'b1; bready_i = 1'b1;
        @(negedge clk);
        rready_i = 1'b0; bready_i = 1'b0;
        axi_read(32'h300, 8'd0, 2'b01, 4'd7, 16'hFFFF, ev(64'h22, 0, 0, 0, 0, 0, 0, 0), 2'b00, "rbw_new");

        // reset in the middle of a read burst with a write burst also open
        @(negedge clk);
        araddr_i = 32'h100; arlen_i = 8'd7; arburst_i = 2'b01; arid_i = 4'd8; arvalid_i = 1'b1;
        awaddr_i = 32'h400; awlen_i = 8'd3; awburst_i = 2'b01; awid_i = 4'd9; awvalid_i = 1'b1;
        @(negedge clk);
        arvalid_i = 1'b0; awvalid_i = 1'b0;
        rready_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rvalid_before_rst", 64'(rvalid_o), 64'd1);
        chk("mid_beat3_data", rdata_o, 64'hA3);
        rst = 1'b1;
        @(negedge clk);
        rready_i = 1'b0;
        chk("mid_rst_rvalid", 64'(rvalid_o), 64'd0);
        chk("mid_rst_bvalid", 64'(bvalid_o), 64'd0);
        chk("mid_rst_arready", 64'(arready_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rel_arready", 64'(arready_o), 64'd1);
        chk("mid_rel_awready", 64'(awready_o), 64'd1);
        chk("mid_rel_rvalid", 64'(rvalid_o), 64'd0);
        @(negedge clk);
        chk("mid_rel_bvalid", 64'(bvalid_o), 64'd0);
        axi_read(vecs[0].addr, vecs[0].len, vecs[0].burst, 4'd10, 16'hFFFF, vecs[0].exp, 2'b00, "mid_reread");

        // accesses beyond DEPTH_WORDS*8 bytes
        axi_write(32'h0, 8'd0, 2'b01, 4'd11, 64'h77, 8'hFF, 1'b1, 2'b00, "wr_word0");
`ifdef AXI_RAM_BOUNDS_CHECK_EN
        axi_read(32'h8000, 8'd0, 2'b01, 4'd12, 16'hFFFF, ev(0, 0, 0, 0, 0, 0, 0, 0), 2'b10, "oob_rd");
        axi_write(32'h8000, 8'd0, 2'b01, 4'd13, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1, 2'b10, "oob_wr");
        axi_read(32'h0, 8'd0, 2'b01, 4'd14, 16'hFFFF, ev(64'h77, 0, 0, 0, 0, 0, 0, 0), 2'b00, "oob_unchanged");
`else
        axi_read(32'h8000, 8'd0, 2'b01, 4'd12, 16'hFFFF, ev(64'h77, 0, 0, 0, 0, 0, 0, 0), 2'b00, "alias_rd");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
